instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit_pkg.sv | 21 ++
 rtl/instr_fetch_unit_fetch_queue.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package instr_fetch_unit_pkg;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  localparam int          FETCH_QDEPTH = 2;
  localparam logic [31:0] RESET_PC     = 32'h0;

  typedef struct packed {
    logic [31:0] pcplus4;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry FIFO between instruction memory and decode; head is driven from storage registers.
module fetch_queue
  import instr_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_push_data,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  localparam logic [1:0] QFULL = 2'(FETCH_QDEPTH);

  fetch_entry_t r_mem [FETCH_QDEPTH];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_push = i_push & (r_count != QFULL);
  assign w_do_pop  = i_pop & (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_QDEPTH; i++) r_mem[i] <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      // Stale entries stay in storage but are unreachable once count is zero.
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= ~r_wr;
      end
      if (w_do_pop) r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word fetches, buffers returned instructions for decode, handles redirects.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        instr_valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d
);

  localparam logic [1:0] QFULL = 2'(FETCH_QDEPTH);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_tgt;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_tgt_nxt;
  logic [31:0]  w_redirect_tgt;
  logic         r_req;
  logic         w_req_nxt;
  logic         w_xfer;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_count;
  logic [1:0]   w_count_nxt;
  fetch_entry_t w_push_data;
  fetch_entry_t w_head;

  assign w_redirect_tgt = word_align(redirect_pc);
  assign w_xfer         = r_req & imem_ack;
  assign w_pop          = instr_valid_d & ~stall_d & ~redirect_valid;
  assign w_push         = w_xfer & ~redirect_valid & (r_state == FETCH);
  assign w_push_data    = '{pcplus4: r_pc + 32'd4, instr: imem_rdata};
  assign w_count_nxt    = redirect_valid ? 2'd0
                                         : w_count + {1'b0, w_push} - {1'b0, w_pop};

  fetch_queue u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .i_push_data (w_push_data),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_req   <= w_req_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    case (r_state)
      FETCH: begin
        if (redirect_valid) begin
          // An outstanding request cannot be withdrawn, so its data must be dropped later.
          if (r_req && !imem_ack) begin
            w_state_nxt = DISCARD;
            w_tgt_nxt   = w_redirect_tgt;
          end else begin
            w_pc_nxt = w_redirect_tgt;
          end
        end else if (w_xfer) begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      DISCARD: begin
        if (redirect_valid) w_tgt_nxt = w_redirect_tgt;
        if (w_xfer) begin
          w_state_nxt = FETCH;
          w_pc_nxt    = redirect_valid ? w_redirect_tgt : r_tgt;
        end
      end
    endcase
    // Hold a raised request until accepted; otherwise request whenever a slot will be free.
    w_req_nxt = (r_req & ~imem_ack) | ((w_state_nxt == FETCH) & (w_count_nxt < QFULL));
  end

  assign imem_req      = r_req;
  assign imem_addr     = r_pc;
  assign instr_valid_d = (w_count != 2'd0);
  assign instr_d       = w_head.instr;
  assign pcplus4_d     = w_head.pcplus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a transaction-level fetch model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall_d = 1'b0;
  logic        instr_valid_d;
  logic [31:0] instr_d;
  logic [31:0] pcplus4_d;

  int errors = 0;
  int checks = 0;
  int consumed = 0;

  // Reference model: expected decode stream plus fetch pointer and discard bookkeeping.
  logic [31:0] q_pc4 [$];
  logic [31:0] q_ins [$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_tgt = 32'h0;
  bit          m_discard = 1'b0;
  bit          p_req = 1'b0;
  bit          p_ack = 1'b0;
  logic [31:0] p_addr = 32'h0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .instr_valid_d  (instr_valid_d),
    .instr_d        (instr_d),
    .pcplus4_d      (pcplus4_d)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h13579BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkb(name, imem_req, 1'b1);
  endtask

  // Monitor: mid-cycle compare against the model, then advance the model over the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_pc4.delete();
      q_ins.delete();
      m_pc      = 32'h0;
      m_tgt     = 32'h0;
      m_discard = 1'b0;
      p_req     = 1'b0;
      p_ack     = 1'b0;
      p_addr    = 32'h0;
    end else begin
      checkb("valid", instr_valid_d, q_pc4.size() != 0);
      if (q_pc4.size() != 0 && instr_valid_d) begin
        check("instr", instr_d, q_ins[0]);
        check("pcplus4", pcplus4_d, q_pc4[0]);
      end
      if (imem_req) check("addr", imem_addr, m_pc);
      check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
      if (q_pc4.size() == 2) checkb("req_full", imem_req, 1'b0);
      if (m_discard) checkb("req_discard", imem_req, 1'b1);
      if (p_req && !p_ack) begin
        checkb("req_hold", imem_req, 1'b1);
        check("addr_hold", imem_addr, p_addr);
      end

      if (redirect_valid) begin
        q_pc4.delete();
        q_ins.delete();
        if (!m_discard && imem_req && !imem_ack) begin
          m_discard = 1'b1;
          m_tgt     = {redirect_pc[31:2], 2'b00};
        end else if (m_discard && !imem_ack) begin
          m_tgt = {redirect_pc[31:2], 2'b00};
        end else begin
          m_pc      = {redirect_pc[31:2], 2'b00};
          m_discard = 1'b0;
        end
      end else begin
        if (q_pc4.size() != 0 && !stall_d) begin
          void'(q_pc4.pop_front());
          void'(q_ins.pop_front());
          consumed++;
        end
        if (imem_req && imem_ack) begin
          if (m_discard) begin
            m_pc      = m_tgt;
            m_discard = 1'b0;
          end else begin
            q_pc4.push_back(m_pc + 32'd4);
            q_ins.push_back(mem_word(m_pc));
            m_pc = m_pc + 32'd4;
          end
        end
      end
      p_req  = imem_req;
      p_ack  = imem_ack;
      p_addr = imem_addr;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkb("rst_req", imem_req, 1'b0);
    checkb("rst_valid", instr_valid_d, 1'b0);
    check("rst_instr", instr_d, 32'h0);
    check("rst_pc4", pcplus4_d, 32'h0);
    step(3);

    // Streaming: ack every cycle, no stall.
    imem_ack = 1'b1;
    rst_n    = 1'b1;
    wait_req("first_req");
    check("first_addr", imem_addr, 32'h0);
    step(12);

    // Decode stall fills the queue and throttles requests.
    stall_d = 1'b1;
    step(5);
    checkb("stall_req_low", imem_req, 1'b0);
    checkb("stall_valid", instr_valid_d, 1'b1);
    stall_d = 1'b0;
    step(6);

    // Redirect during a pending fetch: its data is dropped, new target fetched.
    imem_ack = 1'b0;
    step(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step(1);
    redirect_valid = 1'b0;
    imem_ack       = 1'b1;
    step(1);
    imem_ack = 1'b0;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    imem_ack = 1'b1;
    step(1);
    imem_ack = 1'b0;
    wait_req("req_after_discard");
    check("discard_next_addr", imem_addr, 32'h40);
    checkb("discard_dropped", instr_valid_d, 1'b0);

    // Redirect coinciding with a transfer and a pop.
    step(1);
    imem_ack = 1'b1;
    step(4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step(1);
    redirect_valid = 1'b0;
    checkb("flush_valid", instr_valid_d, 1'b0);
    check("redir_addr", imem_addr, 32'h80);
    step(3);

    // Address wrap at the top of memory.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step(1);
    redirect_valid = 1'b0;
    check("wrap_src_addr", imem_addr, 32'hFFFF_FFFC);
    step(1);
    checkb("wrap_valid", instr_valid_d, 1'b1);
    check("wrap_pc4", pcplus4_d, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      imem_ack       = ($urandom_range(0, 9) < 6);
      stall_d        = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      step(1);
    end

    // Asynchronous reset while a request is pending and the queue holds an entry.
    imem_ack       = 1'b1;
    stall_d        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step(1);
    redirect_valid = 1'b0;
    stall_d        = 1'b1;
    step(1);
    imem_ack = 1'b0;
    checkb("pre_rst_req", imem_req, 1'b1);
    checkb("pre_rst_valid", instr_valid_d, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    checkb("async_req", imem_req, 1'b0);
    checkb("async_valid", instr_valid_d, 1'b0);
    check("async_instr", instr_d, 32'h0);
    step(2);
    stall_d = 1'b0;
    rst_n   = 1'b1;
    wait_req("post_rst_req");
    check("post_rst_addr", imem_addr, 32'h0);
    step(2);

    checkb("liveness", consumed > 200, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
